// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_NINE = 4'h9;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
  localparam state_t DONE  = 2'd2;

  // Ceiling log2, used to size the shift counter for a count of WIDTH.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adjusted
);
  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
endmodule

// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with start/busy/done
// handshake, overflow saturation and a leading-zero blank mask.
module bcd_convert_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [WIDTH-1:0]          binary,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                      overflow,
  output logic [DIGITS-1:0]         lz_mask
);
  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = clog2(WIDTH + 1);

  state_t            state;
  logic [SR_W-1:0]   sreg;
  logic [SR_W-1:0]   shifted;
  logic [BCD_W-1:0]  adj_digits;
  logic [BCD_W-1:0]  fin_digits;
  logic [CNT_W-1:0]  cnt;
  logic              ovf_acc;
  logic              ovf_fin;
  logic [DIGITS-1:0] lz_next;
  logic              zero_run;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit    (sreg[WIDTH + g*DIGIT_W +: DIGIT_W]),
        .adjusted (adj_digits[g*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  // The corrected top bit falls off the shift; any 1 there means >= 10^DIGITS.
  assign shifted    = {adj_digits[BCD_W-2:0], sreg[WIDTH-1:0], 1'b0};
  assign ovf_fin    = ovf_acc | adj_digits[BCD_W-1];
  assign fin_digits = shifted[SR_W-1 -: BCD_W];

  always_comb begin
    lz_next  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run   = zero_run & (fin_digits[i*DIGIT_W +: DIGIT_W] == 4'h0);
      lz_next[i] = zero_run;
    end
  end

  assign busy = (state == SHIFT) || (state == DONE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sreg     <= '0;
      cnt      <= '0;
      ovf_acc  <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      lz_mask  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sreg    <= {{BCD_W{1'b0}}, binary};
            cnt     <= CNT_W'(WIDTH);
            ovf_acc <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          sreg    <= shifted;
          cnt     <= cnt - CNT_W'(1);
          ovf_acc <= ovf_fin;
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
            if (ovf_fin) begin
              bcd      <= {DIGITS{BCD_NINE}};
              overflow <= 1'b1;
              lz_mask  <= '0;
            end else begin
              bcd      <= fin_digits;
              overflow <= 1'b0;
              lz_mask  <= lz_next;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_convert_seq.sv
// Directed bench for bcd_convert_seq: 5-digit and 4-digit instances checked every
// cycle against an arithmetic model, plus hand-computed literal expectations.
module tb_bcd_convert_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] binary = 16'd0;

  logic        busy5, done5, ovf5;
  logic [19:0] bcd5;
  logic [4:0]  lz5;
  logic        busy4, done4, ovf4;
  logic [15:0] bcd4;
  logic [3:0]  lz4;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  bcd_convert_seq #(.WIDTH(16), .DIGITS(5)) dut5 (
    .clk(clk), .reset(reset), .start(start), .binary(binary),
    .busy(busy5), .done(done5), .bcd(bcd5), .overflow(ovf5), .lz_mask(lz5)
  );

  bcd_convert_seq #(.WIDTH(16), .DIGITS(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .binary(binary),
    .busy(busy4), .done(done4), .bcd(bcd4), .overflow(ovf4), .lz_mask(lz4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decimal conversion by plain arithmetic; digit i is blank iff value < 10^i.
  function automatic void model_conv(input int v, input int d, output logic [19:0] b,
                                     output logic o, output logic [4:0] lz);
    int lim;
    int t;
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    b  = '0;
    lz = '0;
    o  = 1'b0;
    if (v >= lim) begin
      o = 1'b1;
      for (int i = 0; i < d; i++) b[i*4 +: 4] = 4'h9;
    end else begin
      t = v;
      for (int i = 0; i < d; i++) begin
        b[i*4 +: 4] = 4'(t % 10);
        t = t / 10;
      end
      t = 10;
      for (int i = 1; i < d; i++) begin
        lz[i] = (v < t);
        t = t * 10;
      end
    end
  endfunction

  // Model timing: a conversion occupies 17 edges after acceptance, done on the
  // 16th; start is looked at only when no conversion is outstanding.
  int          m_left [2];
  int          m_val  [2];
  logic [19:0] m_bcd  [2];
  logic        m_ovf  [2];
  logic [4:0]  m_lz   [2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_left[k] = 0;
        m_bcd[k]  = '0;
        m_ovf[k]  = 1'b0;
        m_lz[k]   = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_left[k] == 0) begin
          if (start) begin
            m_val[k]  = int'(binary);
            m_left[k] = 17;
          end
        end else begin
          m_left[k]--;
          if (m_left[k] == 1)
            model_conv(m_val[k], (k == 0) ? 5 : 4, m_bcd[k], m_ovf[k], m_lz[k]);
        end
      end
    end
  end

  always @(negedge clk) begin
    check("busy5", 32'(busy5), 32'(m_left[0] != 0));
    check("done5", 32'(done5), 32'(m_left[0] == 1));
    check("bcd5",  32'(bcd5),  32'(m_bcd[0]));
    check("ovf5",  32'(ovf5),  32'(m_ovf[0]));
    check("lz5",   32'(lz5),   32'(m_lz[0]));
    check("busy4", 32'(busy4), 32'(m_left[1] != 0));
    check("done4", 32'(done4), 32'(m_left[1] == 1));
    check("bcd4",  32'(bcd4),  32'(m_bcd[1][15:0]));
    check("ovf4",  32'(ovf4),  32'(m_ovf[1]));
    check("lz4",   32'(lz4),   32'(m_lz[1][3:0]));
  end

  int acc_cyc;

  task automatic pulse_start(input logic [15:0] v);
    @(posedge clk); #1;
    binary = v;
    start  = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(output int at);
    bit seen;
    seen = 0;
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done5) begin
        seen = 1;
        at = cyc;
        break;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int t0, t1, t2;
    #2 reset = 1'b1;
    @(negedge clk);
    check("rst_bcd5", 32'(bcd5), 32'h0);
    check("rst_busy5", 32'(busy5), 32'h0);
    check("rst_done5", 32'(done5), 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    // 1: basic conversion and latency from the accepting edge
    pulse_start(16'd1234);
    wait_done(t0);
    check("t1_latency", 32'(t0 - acc_cyc), 32'd16);
    check("t1_bcd", 32'(bcd5), 32'h01234);
    check("t1_lz", 32'(lz5), 32'b10000);
    check("t1_ovf", 32'(ovf5), 32'd0);

    // 2: back-to-back 65535 then 0, start held across the handoff
    @(posedge clk); #1;
    binary = 16'd65535;
    start  = 1'b1;
    @(posedge clk); #1 binary = 16'd0;
    wait_done(t0);
    check("t2_bcd_max", 32'(bcd5), 32'h65535);
    check("t2_lz_max", 32'(lz5), 32'b00000);
    @(posedge clk); #1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(t0);
    check("t2_bcd_zero", 32'(bcd5), 32'h00000);
    check("t2_lz_zero", 32'(lz5), 32'b11110);

    // 3: four-digit overflow then in-range clears it
    pulse_start(16'd12345);
    wait_done(t0);
    check("t3_bcd4_sat", 32'(bcd4), 32'h9999);
    check("t3_ovf4", 32'(ovf4), 32'd1);
    check("t3_lz4", 32'(lz4), 32'd0);
    check("t3_bcd5", 32'(bcd5), 32'h12345);
    pulse_start(16'd42);
    wait_done(t0);
    check("t3_ovf4_clr", 32'(ovf4), 32'd0);
    check("t3_bcd4", 32'(bcd4), 32'h0042);
    check("t3_lz4_42", 32'(lz4), 32'b1100);

    // 4: start held high -> one done every 18 cycles
    @(posedge clk); #1;
    binary = 16'd300;
    start  = 1'b1;
    wait_done(t0);
    wait_done(t1);
    wait_done(t2);
    start = 1'b0;
    check("t4_period_a", 32'(t1 - t0), 32'd18);
    check("t4_period_b", 32'(t2 - t1), 32'd18);
    check("t4_bcd", 32'(bcd5), 32'h00300);
    repeat (3) @(posedge clk);

    // 5: reset in the 8th SHIFT cycle aborts, then a fresh conversion
    pulse_start(16'd4321);
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("t5_bcd_clr", 32'(bcd5), 32'h0);
    check("t5_busy_clr", 32'(busy5), 32'd0);
    check("t5_ovf_clr", 32'(ovf5), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    check("t5_no_done_bcd", 32'(bcd5), 32'h0);
    pulse_start(16'd999);
    wait_done(t0);
    check("t5_bcd", 32'(bcd5), 32'h00999);
    check("t5_lz", 32'(lz5), 32'b11000);

    // 6: input changes after capture do not affect the result
    pulse_start(16'd500);
    repeat (4) @(posedge clk);
    #1 binary = 16'd77;
    wait_done(t0);
    check("t6_bcd", 32'(bcd5), 32'h00500);
    check("t6_lz", 32'(lz5), 32'b11000);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
